// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a centred 256x256 double-buffered framebuffer with a
// two-stage read pipeline. Define BORDER_EN to draw a grey 1-pixel frame around the image.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_X0   = 192,
  parameter int IMG_Y0   = 112,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fb_rd_en,
  output logic [16:0] fb_rd_addr,
  input  logic [23:0] fb_rd_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        fb_sel,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_BEG  = 10'(IMG_X0);
  localparam logic [9:0] X_END  = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0] Y_BEG  = 10'(IMG_Y0);
  localparam logic [9:0] Y_END  = 10'(IMG_Y0 + IMG_H);

  typedef enum logic {
    SWAP_IDLE,
    SWAP_ACKED
  } swap_state_e;

  function automatic logic in_img_f(input logic [9:0] h, input logic [9:0] v);
    return (h >= X_BEG) && (h < X_END) && (v >= Y_BEG) && (v < Y_END);
  endfunction

`ifdef BORDER_EN
  localparam logic [9:0]  X_BRD_L    = 10'(IMG_X0 - 1);
  localparam logic [9:0]  X_BRD_R    = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0]  Y_BRD_T    = 10'(IMG_Y0 - 1);
  localparam logic [9:0]  Y_BRD_B    = 10'(IMG_Y0 + IMG_H);
  localparam logic [23:0] BORDER_RGB = 24'h808080;

  function automatic logic border_f(input logic [9:0] h, input logic [9:0] v);
    logic col_edge, row_edge, col_span, row_span;
    col_edge = (h == X_BRD_L) || (h == X_BRD_R);
    row_edge = (v == Y_BRD_T) || (v == Y_BRD_B);
    col_span = (h >= X_BRD_L) && (h <= X_BRD_R);
    row_span = (v >= Y_BRD_T) && (v <= Y_BRD_B);
    return (col_edge && row_span) || (row_edge && col_span);
  endfunction
`endif

  // Counters and swap state
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  swap_state_e state_q, state_d;
  logic        fb_sel_q, fb_sel_d;
  logic        ack;
  logic        frame_pt;

  // Stage 0: read request, computed from the next counter value so it lines up with h_q/v_q
  logic        rd_en_q;
  logic [16:0] rd_addr_q;
  logic [7:0]  x_off_d, y_off_d;

  // Stage 1: terms that travel alongside the RAM read
  logic        s1_img_q;
  logic        s1_act_q;
  logic        s1_hs_q;
  logic        s1_vs_q;
`ifdef BORDER_EN
  logic        s1_border_q;
`endif

  // Stage 2: registered VGA outputs
  logic [23:0] rgb_q, rgb_d;
  logic        hs_n_q, vs_n_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  assign x_off_d  = 8'(h_d - X_BEG);
  assign y_off_d  = 8'(v_d - Y_BEG);
  assign frame_pt = (h_q == '0) && (v_q == Y_ACT);

  // A request raised after frame_pt waits for the next frame; staying in ACKED
  // until the request drops keeps a held request from flipping twice.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d  = state_q;
    fb_sel_d = fb_sel_q;
    ack      = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (frame_pt && swap_req) begin
          fb_sel_d = ~fb_sel_q;
          ack      = 1'b1;
          state_d  = SWAP_ACKED;
        end
      end
      SWAP_ACKED: begin
        if (!swap_req) state_d = SWAP_IDLE;
      end
    endcase
  end

  always_comb begin
    rgb_d = '0;
    if (s1_act_q) begin
      if (s1_img_q) begin
        rgb_d = fb_rd_data;
      end
`ifdef BORDER_EN
      else if (s1_border_q) begin
        rgb_d = BORDER_RGB;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q         <= '0;
      v_q         <= '0;
      state_q     <= SWAP_IDLE;
      fb_sel_q    <= 1'b0;
      // NOTE: the pipeline stages are reset too (not just the counters), so the
      // first pixels after release are black rather than stale data.
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      s1_img_q    <= 1'b0;
      s1_act_q    <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
`ifdef BORDER_EN
      s1_border_q <= 1'b0;
`endif
      rgb_q       <= '0;
      hs_n_q      <= 1'b1;
      vs_n_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here, so every stage samples the values
      // from before this edge regardless of statement order.
      h_q         <= h_d;
      v_q         <= v_d;
      state_q     <= state_d;
      fb_sel_q    <= fb_sel_d;
      rd_en_q     <= in_img_f(h_d, v_d);
      rd_addr_q   <= {fb_sel_d, y_off_d, x_off_d};
      s1_img_q    <= rd_en_q;
      s1_act_q    <= (h_q < X_ACT) && (v_q < Y_ACT);
      s1_hs_q     <= (h_q >= HS_BEG) && (h_q < HS_END);
      s1_vs_q     <= (v_q >= VS_BEG) && (v_q < VS_END);
`ifdef BORDER_EN
      s1_border_q <= border_f(h_q, v_q);
`endif
      rgb_q       <= rgb_d;
      hs_n_q      <= ~s1_hs_q;
      vs_n_q      <= ~s1_vs_q;
    end
  end

  assign fb_rd_en   = rd_en_q;
  assign fb_rd_addr = rd_addr_q;
  assign swap_ack   = ack;
  assign fb_sel     = fb_sel_q;
  assign vga_r      = rgb_q[23:16];
  assign vga_g      = rgb_q[15:8];
  assign vga_b      = rgb_q[7:0];
  assign vga_hs     = hs_n_q;
  assign vga_vs     = vs_n_q;
  assign vblank     = (v_q >= Y_ACT);

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream display stage of the graph renderer: scans the 256x256 framebuffer and drives a 640x480@60 VGA port, with the image centred and black around it.
- Generates H/V timing, issues framebuffer read addresses, and realigns sync to the RAM read latency.
- Runs a swap handshake so the renderer can double-buffer: the buffer flips only in vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_X0, 192, first screen column of the image
- IMG_Y0, 112, first screen line of the image

Ports:
- clk  in  1  pixel clock (25.175/25 MHz)
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  17  {fb_sel, y[7:0], x[7:0]}
- fb_rd_data  in  24  {R[7:0],G[7:0],B[7:0]}; valid the cycle after fb_rd_en
- swap_req  in  1  renderer: back buffer complete; level, held until ack
- swap_ack  out  1  one-cycle pulse: buffers flipped
- fb_sel  out  1  buffer currently displayed
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hs, vga_vs  out  1 each  sync, active-low
- vblank  out  1  high while v_cnt >= V_ACTIVE (counter-aligned, not delayed)

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1 (800), v_cnt 0..V_TOTAL-1 (525). h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 after 524. Counters are 10 bits wide.
- Window: in_img = (IMG_X0 <= h_cnt < IMG_X0+256) && (IMG_Y0 <= v_cnt < IMG_Y0+256).
- Stage 0 (registered outputs): fb_rd_en = in_img; fb_rd_addr = {fb_sel, v_cnt-IMG_Y0 [7:0], h_cnt-IMG_X0 [7:0]}. The address is don't-care when fb_rd_en = 0.
- Stage 1: the RAM returns fb_rd_data. in_img, active and the raw sync terms are delayed one cycle in lockstep.
- Stage 2: vga_* registered.
  - Colour = fb_rd_data if the delayed in_img is set, else 0.
  - Colour is forced to 0 outside the active area.
- Latency: vga_hs, vga_vs and colour appear exactly 2 cycles after the counter value that produced them.
- Sync: hs is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751). vs is low for V_ACTIVE+V_FP <= v_cnt < +V_SYNC (490..491).
- Swap FSM, states IDLE and ACKED:
  - IDLE: on the cycle h_cnt==0 && v_cnt==V_ACTIVE with swap_req=1, toggle fb_sel, pulse swap_ack, go to ACKED.
  - ACKED: return to IDLE when swap_req=0.
  - swap_req asserted after that cycle waits for the next frame (at most one flip per frame).
  - swap_req still high one frame after the ack does not flip again until it drops.
  - The fb_sel change is first visible in fb_rd_addr on line IMG_Y0 of the next frame, so it never tears.
- Reset (rst=0, including mid-frame), on the next edge:
  - h_cnt = v_cnt = 0, fb_sel = 0, FSM = IDLE.
  - swap_ack = 0, fb_rd_en = 0, colour = 0.
  - vga_hs = vga_vs = 1.
  - Pipeline registers cleared, so no stale pixel is emitted after release.
- First cycle after release: h_cnt = 0, v_cnt = 0 (start of the active frame).

Optional Feature:
- Macro: BORDER_EN.
- Defined: a 1-pixel grey frame (R=G=B=0x80) is drawn just outside the image: columns IMG_X0-1 and IMG_X0+256 over lines IMG_Y0-1..IMG_Y0+256, plus lines IMG_Y0-1 and IMG_Y0+256 over the same column span. Same 2-cycle latency; fb_rd_en stays low there.
- Undefined: those pixels are black. No other difference.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> vga_hs=vga_vs=1, colour 0, fb_sel=0, swap_ack=0, fb_rd_en=0; after release, first hs falling edge at cycle 656+2.
- Timing: run 2 frames -> hs low 96 cycles every 800; vs low exactly 1600 cycles every 420000; vblank high 45 lines per frame.
- Mapping: RAM model with pixel(x,y)={x,y,8'h5A} -> screen (192,112) shows {00,00,5A}; (447,367) shows {FF,FF,5A}; (191,112) and (448,367) black; every outgoing address bit 16 = fb_sel.
- Swap: assert swap_req at line 300 -> single swap_ack at v_cnt=480,h_cnt=0, fb_sel 0->1; hold req 3 frames -> no further flip; drop then re-raise -> next flip at the following vblank start.
- Reset mid-frame at line 200, col 300 -> next cycle all outputs at reset values; fb_sel returns to 0 after a prior flip; a clean frame restarts on release.
- BORDER_EN build: pixels (191,150), (448,150), (300,111), (300,368) = 0x808080; (190,150) black; unset build: all four black.
